// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and a word-addressed data memory.
// Sub-word stores are done as read-modify-write, so the memory only sees full-word accesses.
module mem_access_unit #(
  parameter int ADDR_WORDS = 256
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Req_Valid,
  output logic        Req_Ready,
  input  logic        Req_Write,
  input  logic [1:0]  Req_Size,
  input  logic        Req_Unsigned,
  input  logic [31:0] Req_Address,
  input  logic [31:0] Req_Store_Data,
  output logic        Resp_Valid,
  output logic        Resp_Error,
  output logic [31:0] Load_Data,
  output logic [31:0] Mem_Address,
  output logic [31:0] Mem_Write_Data,
  output logic        Mem_MemRead,
  output logic        Mem_MemWrite,
  input  logic [31:0] Mem_Read_Data
);

  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  state_t      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [31:0] store_data_q, store_data_d;
  logic        ready_q, ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_error_q, resp_error_d;
  logic [31:0] load_data_q, load_data_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;

  logic        req_err;
  logic [4:0]  shamt;
  logic [31:0] field_mask;
  logic [31:0] rd_shifted;
  logic [31:0] ext_load;
  logic [31:0] merged;

  assign req_err = (Req_Size == 2'b11)
                || (Req_Size == SIZE_HALF && Req_Address[0])
                || (Req_Size == SIZE_WORD && Req_Address[1:0] != 2'b00)
                || ({2'b00, Req_Address[31:2]} >= 32'(ADDR_WORDS));

  // Little-endian lanes: the latched byte offset selects the field position.
  assign shamt      = {lane_q, 3'b000};
  assign field_mask = (size_q == SIZE_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF;
  assign rd_shifted = Mem_Read_Data >> shamt;
  assign merged     = (Mem_Read_Data & ~(field_mask << shamt))
                    | ((store_data_q & field_mask) << shamt);

  always_comb begin
    case (size_q)
      SIZE_BYTE: ext_load = unsigned_q ? {24'h0, rd_shifted[7:0]}
                                       : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      SIZE_HALF: ext_load = unsigned_q ? {16'h0, rd_shifted[15:0]}
                                       : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      default:   ext_load = rd_shifted;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    lane_d       = lane_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    store_data_d = store_data_q;
    ready_d      = ready_q;
    load_data_d  = load_data_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (Req_Valid) begin
          lane_d       = Req_Address[1:0];
          size_d       = Req_Size;
          unsigned_d   = Req_Unsigned;
          store_data_d = Req_Store_Data;
          mem_addr_d   = {2'b00, Req_Address[31:2]};
          load_data_d  = 32'h0;
          ready_d      = 1'b0;
          if (req_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else if (!Req_Write) begin
            state_d  = LOAD;
            mem_rd_d = 1'b1;
          end else if (Req_Size == SIZE_WORD) begin
            state_d     = STORE;
            mem_wr_d    = 1'b1;
            mem_wdata_d = Req_Store_Data;
          end else begin
            state_d  = RMW_RD;
            mem_rd_d = 1'b1;
          end
        end
      end
      LOAD: begin
        load_data_d  = ext_load;
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      STORE, RMW_WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      RMW_RD: begin
        mem_wdata_d = merged;
        mem_wr_d    = 1'b1;
        state_d     = RMW_WR;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      lane_q       <= 2'b00;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      store_data_q <= 32'h0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      load_data_q  <= 32'h0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      store_data_q <= store_data_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      load_data_q  <= load_data_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
    end
  end

  assign Req_Ready      = ready_q;
  assign Resp_Valid     = resp_valid_q;
  assign Resp_Error     = resp_error_q;
  assign Load_Data      = load_data_q;
  assign Mem_Address    = mem_addr_q;
  assign Mem_Write_Data = mem_wdata_q;
  assign Mem_MemRead    = mem_rd_q;
  assign Mem_MemWrite   = mem_wr_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit between the pipeline's MEM stage and the word-addressed, level-sensitive data memory. Accepts byte/halfword/word load and store requests on a valid/ready handshake. Translates byte addresses to word indices and performs sign/zero extension for loads. Uses read-modify-write for sub-word stores, so the memory only ever sees full-word MemRead/MemWrite accesses.

## Interface
- ADDR_WORDS, 256, number of 32-bit words in the data memory; word indices >= ADDR_WORDS are out of range.
- Clock  input  1  single clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Req_Valid  input  1  request present.
- Req_Ready  output  1  unit idle, can accept; high only in IDLE.
- Req_Write  input  1  1 = store, 0 = load.
- Req_Size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- Req_Unsigned  input  1  zero-extend sub-word loads (LBU/LHU); ignored for stores/LW.
- Req_Address  input  32  byte address.
- Req_Store_Data  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- Resp_Valid  output  1  one-cycle completion pulse.
- Resp_Error  output  1  qualifies Resp_Valid: misaligned, illegal size or out of range.
- Load_Data  output  32  extended load result; valid with Resp_Valid.
- Mem_Address  output  32  word index to the data memory (byte address >> 2).
- Mem_Write_Data  output  32  full word to write.
- Mem_MemRead  output  1  memory read strobe.
- Mem_MemWrite  output  1  memory write strobe.
- Mem_Read_Data  input  32  memory read word; combinational from Mem_Address while Mem_MemRead is high.

## Operation
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- In IDLE, accept on a rising edge with Req_Valid && Req_Ready. Latch the address (word index = Req_Address[31:2], lane = [1:0]), size, unsigned flag and store data.
- Error check at accept:
  - size 11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - word index >= ADDR_WORDS.
  - Any error -> RESP with Resp_Error=1 and Load_Data=0. No memory strobe is ever asserted.
- Load -> LOAD: Mem_MemRead=1. Extract the field from Mem_Read_Data, extend it and register it into Load_Data at the exit edge -> RESP.
- Word store -> STORE: Mem_MemWrite=1, Mem_Write_Data=store data -> RESP.
- Byte/half store -> RMW_RD: Mem_MemRead=1, capture the word -> RMW_WR.
  - RMW_WR: Mem_MemWrite=1 with the merged word; only the addressed lane(s) are replaced -> RESP.
- Lanes are little-endian:
  - byte lane b = bits [8b+7:8b];
  - half at addr[1] occupies bits [16*addr[1]+15 : 16*addr[1]].
- Signed loads replicate the field MSB into the upper bits; unsigned loads fill the upper bits with 0.
- RESP: Resp_Valid=1 for exactly one cycle, then IDLE. The response has no backpressure; the consumer must take it.
- Mem_MemRead and Mem_MemWrite are never high together. Both are 0 in IDLE and RESP.
- Mem_Address and Mem_Write_Data are registered and stable for the whole strobe cycle.
- Store and error responses drive Load_Data=0.

## Timing
- Reset values: state IDLE, Req_Ready=1, Resp_Valid=0, Resp_Error=0, Load_Data=0, Mem_Address=0, Mem_Write_Data=0, Mem_MemRead=0, Mem_MemWrite=0.
- Counting from the accept edge k:
  - LW/LB/LH, SW: strobe cycle k..k+1, Resp_Valid cycle k+1..k+2.
  - SB/SH: read cycle k..k+1, write cycle k+1..k+2, Resp_Valid k+2..k+3.
  - Error: Resp_Valid k..k+1.
- Req_Ready drops the cycle after accept and returns the cycle after RESP. A held Req_Valid is accepted again one edge after the Resp_Valid cycle.
- Reset mid-operation: every output returns to its reset value immediately (asynchronously) and no Resp_Valid is issued. If reset lands in RMW_RD, memory is unchanged. A write already strobed is not rolled back.
- Request inputs are ignored outside IDLE.

## Test plan
- Reset, word 3 = 4; LW addr 0x0C -> Mem_Address=3, MemRead for 1 cycle, Resp_Valid at k+1 with Load_Data=0x00000004, Resp_Error=0.
- Word 7 = 0x00000008; SB addr 0x1D data 0x000000AB -> MemRead then MemWrite of 0x0000AB08 at index 7. Then LB 0x1D -> 0xFFFFFFAB; LBU 0x1D -> 0x000000AB.
- Word 8 = 0; SH addr 0x22 data 0x12348001 -> write 0x80010000. Then LH 0x22 -> 0xFFFF8001; LHU -> 0x00008001; LW 0x20 -> 0x80010000.
- Error cases, each -> Resp_Error=1, Load_Data=0, strobes stay 0:
  - LW addr 0x06;
  - LH addr 0x03;
  - Req_Size=11;
  - SW addr 0x400 (index 256, ADDR_WORDS=256).
- Reset pulsed during RMW_RD of SB addr 0x1C -> strobes drop the same cycle, Req_Ready=1, no Resp_Valid, word 7 unchanged.
- Req_Valid held high for LW,SW,SB,LB back-to-back -> Req_Ready low while busy, each accepted one edge after the prior Resp_Valid, never two strobes at once.
